sram_req_adapter: RTL

- Request/response front end sitting directly upstream of the 64-bit byte-enable single-port SRAM wrapper (SyncSpRamBeNx64); drives its CSel/WrEn/BEn/Addr/WrData and consumes its RdData.
- Turns a valid/ready request channel into RAM accesses and tracks the RAM's fixed read latency.
- Buffers read data in a response FIFO, so downstream backpressure never loses a beat and requests never stall inside the RAM.

---
 rtl/sram_req_adapter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sram_req_adapter.sv
// Valid/ready request front end for SyncSpRamBeNx64 with credit-limited response FIFO.
// Define SRAM_REQ_ADAPTER_WRITE_ACK_EN to also return in-order write acknowledgements.
module sram_req_adapter #(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REGS   = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrite_SI,
  input  logic [7:0]            ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [63:0]           ReqWrData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [63:0]           RspRdData_DO,
  output logic                  RspWrite_SO,
  output logic                  RamCSel_SO,
  output logic                  RamWrEn_SO,
  output logic [7:0]            RamBEn_SO,
  output logic [ADDR_WIDTH-1:0] RamAddr_DO,
  output logic [63:0]           RamWrData_DO,
  input  logic [63:0]           RamRdData_DI,
  output logic                  Idle_SO
);

  localparam int L  = 1 + OUT_REGS;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic            ready_q;
  logic [CW-1:0]   outst_q;
  logic [CW-1:0]   outst_d;
  logic [L-1:0]    pipe_v_q;
  logic [L-1:0]    pipe_w_q;
  logic [63:0]     fifo_data_q [RSP_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   fill_q;

  logic            accept;
  logic            exit_v;
  logic            exit_w;
  logic            push;
  logic            pop;
  logic            wr_exit;
  logic [63:0]     push_data;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept = ReqValid_SI & ready_q;

  assign RamCSel_SO   = accept;
  assign RamWrEn_SO   = accept & ReqWrite_SI;
  assign RamBEn_SO    = (accept & ReqWrite_SI)
                        ? ReqBEn_SI : 8'h00;
  assign RamAddr_DO   = ReqAddr_DI;
  assign RamWrData_DO = ReqWrData_DI;

  assign exit_v = pipe_v_q[L-1];
  assign exit_w = pipe_w_q[L-1];
  assign pop    = (fill_q != '0) & RspReady_SI;

`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
  logic fifo_wr_q [RSP_DEPTH];

  assign push      = exit_v;
  assign push_data = exit_w ? 64'h0 : RamRdData_DI;
  assign wr_exit   = 1'b0;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      for (int i = 0; i < RSP_DEPTH; i++)
        fifo_wr_q[i] <= 1'b0;
    end else if (push) begin
      fifo_wr_q[wr_ptr_q] <= exit_w;
    end
  end

  assign RspWrite_SO = fifo_wr_q[rd_ptr_q];
`else
  // Writes leave silently; their credit is released as they exit.
  assign push        = exit_v & ~exit_w;
  assign push_data   = RamRdData_DI;
  assign wr_exit     = exit_v & exit_w;
  assign RspWrite_SO = 1'b0;
`endif

  assign outst_d = outst_q
                 + CW'(accept)
                 - CW'(pop)
                 - CW'(wr_exit);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      ready_q  <= 1'b0;
      outst_q  <= '0;
      pipe_v_q <= '0;
      pipe_w_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      ready_q     <= (outst_d < CW'(RSP_DEPTH));
      outst_q     <= outst_d;
      pipe_v_q[0] <= accept;
      pipe_w_q[0] <= accept & ReqWrite_SI;
      for (int i = 1; i < L; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_w_q[i] <= pipe_w_q[i-1];
      end
      if (push)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      fill_q <= fill_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      for (int i = 0; i < RSP_DEPTH; i++)
        fifo_data_q[i] <= 64'h0;
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign ReqReady_SO  = ready_q;
  assign RspValid_SO  = (fill_q != '0);
  assign RspRdData_DO = fifo_data_q[rd_ptr_q];
  assign Idle_SO      = (outst_q == '0);

  a_no_overflow: assert property (
    @(posedge Clk_CI) disable iff (Rst_RI)
    !(push && fill_q == CW'(RSP_DEPTH))
  );

endmodule
